// File: rtl/draw_srcread.sv
// rtl/draw_srcread.sv - AXI4 read-side rectangular VRAM fetch into a tagged pixel stream
module draw_srcread #(
    parameter int FIFO_DEPTH = 512
) (
    input  logic        CLK,
    input  logic        ARST,
    input  logic        START,
    input  logic [31:0] BASE,
    input  logic [10:0] FRM_WIDTH,
    input  logic [10:0] POSX,
    input  logic [10:0] POSY,
    input  logic [10:0] SIZX,
    input  logic [10:0] SIZY,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] M_AXI_ARADDR,
    output logic [7:0]  M_AXI_ARLEN,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic [31:0] PIX_DATA,
    output logic        PIX_VALID,
    input  logic        PIX_READY,
    output logic        PIX_EOL,
    output logic        PIX_EOR
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LINE_INIT, S_CALC, S_AR, S_R, S_NEXT, S_DRAIN
    } state_t;

    state_t        state;
    logic [31:0]   base_r;
    logic [10:0]   fw_r, posx_r, posy_r, sizx_r, sizy_r;
    logic [31:0]   addr;
    logic [10:0]   rem, line;
    logic [8:0]    n, cnt;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, free;
    logic          push, pop;

    logic [10:0]   bound_beats, n_calc, n_ext;
    logic [11:0]   ypos;
    logic [23:0]   pix_off;
    logic [31:0]   line_addr;
    logic          last_beat, beat_eol, beat_eor;
    logic          unused_rlast;

    // Burst length is driven purely by beat count; RLAST carries no extra information.
    assign unused_rlast = M_AXI_RLAST;

    assign free      = (AW+1)'(FIFO_DEPTH) - occ;
    assign push      = (state == S_R) && M_AXI_RVALID && M_AXI_RREADY;
    assign PIX_VALID = (occ != '0);
    assign pop       = PIX_VALID && PIX_READY;
    assign {PIX_EOR, PIX_EOL, PIX_DATA} = PIX_VALID ? mem[rd_ptr] : 34'd0;

    // Line start address, next burst size and per-beat line/region tags.
    always_comb begin
        bound_beats = 11'd1024 - {1'b0, addr[11:2]};
        n_calc = rem;
        if (n_calc > 11'd256)
            n_calc = 11'd256;
        if (n_calc > bound_beats)
            n_calc = bound_beats;
        ypos      = {1'b0, posy_r} + {1'b0, line};
        pix_off   = 24'(ypos) * 24'(fw_r) + 24'(posx_r);
        line_addr = base_r + {6'b0, pix_off, 2'b0};
        n_ext     = {2'b0, n};
        last_beat = (cnt == n - 9'd1);
        beat_eol  = last_beat && (n_ext == rem);
        beat_eor  = beat_eol && (line == sizy_r - 11'd1);
    end

    // Pixel FIFO storage; entries carry {eor, eol, data}.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {beat_eor, beat_eol, M_AXI_RDATA};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                occ <= occ + (AW+1)'(1);
            else if (pop && !push)
                occ <= occ - (AW+1)'(1);
        end
    end

    // Fetch sequencer: one line at a time, one outstanding burst, space reserved before AR.
    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            state         <= S_IDLE;
            base_r        <= '0;
            fw_r          <= '0;
            posx_r        <= '0;
            posy_r        <= '0;
            sizx_r        <= '0;
            sizy_r        <= '0;
            addr          <= '0;
            rem           <= '0;
            line          <= '0;
            n             <= '0;
            cnt           <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        base_r <= BASE;
                        fw_r   <= FRM_WIDTH;
                        posx_r <= POSX;
                        posy_r <= POSY;
                        sizx_r <= SIZX;
                        sizy_r <= SIZY;
                        line   <= '0;
                        BUSY   <= 1'b1;
                        state  <= (SIZX == '0 || SIZY == '0) ? S_DRAIN : S_LINE_INIT;
                    end
                end
                S_LINE_INIT: begin
                    addr  <= line_addr;
                    rem   <= sizx_r;
                    state <= S_CALC;
                end
                S_CALC: begin
                    if (32'(free) >= 32'(n_calc)) begin
                        M_AXI_ARADDR  <= addr;
                        M_AXI_ARLEN   <= 8'(n_calc - 11'd1);
                        n             <= 9'(n_calc);
                        M_AXI_ARVALID <= 1'b1;
                        state         <= S_AR;
                    end
                end
                S_AR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        cnt           <= '0;
                        state         <= S_R;
                    end
                end
                S_R: begin
                    if (M_AXI_RVALID) begin
                        if (last_beat) begin
                            M_AXI_RREADY <= 1'b0;
                            state        <= S_NEXT;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                S_NEXT: begin
                    addr <= addr + {21'b0, n, 2'b0};
                    rem  <= rem - n_ext;
                    if (rem != n_ext) begin
                        state <= S_CALC;
                    end else begin
                        line  <= line + 11'd1;
                        state <= (line + 11'd1 < sizy_r) ? S_LINE_INIT : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (occ == '0) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
